// File: rtl/fp_convert_pkg.sv
// Shared constants and helpers for the pipelined integer-to-float converter.
package fp_convert_pkg;

   localparam logic RND_TRUNC   = 1'b0;
   localparam logic RND_HALF_UP = 1'b1;

   // Largest exponent reachable by an IN_W-bit two's-complement input.
   function automatic int emax_f(input int in_w, input int mant_w);
      return in_w - 1 - mant_w;
   endfunction

endpackage

// File: rtl/fp_convert_pipe_if.sv
// Valid/ready bus for fp_convert_pipe: input word side and result side.
interface fp_convert_pipe_if #(
   parameter int IN_W   = 12,
   parameter int MANT_W = 4,
   parameter int EXP_W  = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [IN_W-1:0]   in_data;
   logic              rnd_mode;
   logic              out_valid;
   logic              out_ready;
   logic              out_sign;
   logic [EXP_W-1:0]  out_exp;
   logic [MANT_W-1:0] out_sig;
   logic              out_sat;

   modport master (
      output in_valid, in_data, rnd_mode, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_sig, out_sat
   );

   modport slave (
      input  in_valid, in_data, rnd_mode, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_sig, out_sat
   );
endinterface

// File: rtl/fp_lzc.sv
// Priority encoder: index of the highest set bit of vec, plus an all-zero flag.
module fp_lzc #(
   parameter int W     = 11,
   parameter int IDX_W = $clog2(W)
) (
   input  logic [W-1:0]     vec,
   output logic [IDX_W-1:0] idx,
   output logic             zero
);

   // Scan upward so the highest set bit wins.
   always_comb begin
      idx = {IDX_W{1'b0}};
      for (int i = 0; i < W; i++) begin
         idx = vec[i] ? IDX_W'(i) : idx;
      end
      zero = ~|vec;
   end

endmodule

// File: rtl/fp_convert_pipe.sv
// Three-stage converter: sign/magnitude, normalise, round/saturate, with
// valid/ready back-pressure through every stage.
module fp_convert_pipe
   import fp_convert_pkg::*;
#(
   parameter int IN_W   = 12,
   parameter int MANT_W = 4,
   parameter int EXP_W  = 3
) (
   input logic           clk,
   input logic           rst_n,
   fp_convert_pipe_if.slave bus
);

   localparam int EMAX  = emax_f(IN_W, MANT_W);
   localparam int MW    = IN_W - 1;
   localparam int IDX_W = $clog2(MW);
   localparam logic [IN_W-1:0]   MOST_NEG  = {1'b1, {MW{1'b0}}};
   localparam logic [IDX_W-1:0]  MSB_MIN   = IDX_W'(MANT_W - 1);
   localparam logic [EXP_W-1:0]  EMAX_E    = EXP_W'(EMAX);
   localparam logic [MANT_W-1:0] SIG_ONES  = {MANT_W{1'b1}};
   localparam logic [MANT_W-1:0] SIG_CARRY = {1'b1, {(MANT_W-1){1'b0}}};

   if (IN_W < MANT_W + 2) begin : g_bad_in_w
      $error("fp_convert_pipe: IN_W must be >= MANT_W+2");
   end
   if ((2 ** EXP_W) - 1 < EMAX) begin : g_bad_exp_w
      $error("fp_convert_pipe: EXP_W too narrow for EMAX");
   end

   logic              ld1_s, ld2_s, ld3_s;
   logic              s1_valid_r, s1_sign_r, s1_sat_r, s1_rnd_r;
   logic [MW-1:0]     s1_mag_r;
   logic              s1_sign_s, s1_sat_s;
   logic [MW-1:0]     s1_mag_s;
   logic [IN_W-1:0]   neg_s;
   logic              s2_valid_r, s2_sign_r, s2_sat_r, s2_rnd_r, s2_rbit_r;
   logic [EXP_W-1:0]  s2_exp_r;
   logic [MANT_W-1:0] s2_sig_r;
   logic [IDX_W-1:0]  p_s, shift_s;
   logic              zero_s, s2_rbit_s;
   logic [MANT_W:0]   ext_s;
   logic [EXP_W-1:0]  s2_exp_s;
   logic [MANT_W-1:0] s2_sig_s;
   logic              s3_valid_r, s3_sign_r, s3_sat_r;
   logic [EXP_W-1:0]  s3_exp_r, s3_exp_s;
   logic [MANT_W-1:0] s3_sig_r, s3_sig_s;
   logic              inc_s, rsat_s;

   // A stage may load when it is empty or its contents leave this cycle.
   assign ld3_s        = !s3_valid_r || bus.out_ready;
   assign ld2_s        = !s2_valid_r || ld3_s;
   assign ld1_s        = !s1_valid_r || ld2_s;
   assign bus.in_ready = ld1_s;

   // S1 combinational: sign and magnitude, clamping the most negative value.
   always_comb begin
      neg_s     = ~bus.in_data + IN_W'(1);
      s1_sign_s = bus.in_data[IN_W-1];
      s1_sat_s  = 1'b0;
      if (bus.in_data == MOST_NEG) begin
         s1_mag_s = {MW{1'b1}};
         s1_sat_s = 1'b1;
      end else if (s1_sign_s) begin
         s1_mag_s = neg_s[MW-1:0];
      end else begin
         s1_mag_s = bus.in_data[MW-1:0];
      end
   end

   // S1 register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_sign_r  <= 1'b0;
         s1_mag_r   <= {MW{1'b0}};
         s1_sat_r   <= 1'b0;
         s1_rnd_r   <= 1'b0;
      end else if (ld1_s) begin
         s1_valid_r <= bus.in_valid;
         if (bus.in_valid) begin
            s1_sign_r <= s1_sign_s;
            s1_mag_r  <= s1_mag_s;
            s1_sat_r  <= s1_sat_s;
            s1_rnd_r  <= bus.rnd_mode;
         end
      end
   end

   fp_lzc #(.W(MW), .IDX_W(IDX_W)) u_lzc (
      .vec  (s1_mag_r),
      .idx  (p_s),
      .zero (zero_s)
   );

   // S2 combinational: one extra low bit in ext_s carries the rounding bit.
   always_comb begin
      shift_s   = {IDX_W{1'b0}};
      ext_s     = {(MANT_W+1){1'b0}};
      s2_exp_s  = {EXP_W{1'b0}};
      s2_sig_s  = s1_mag_r[MANT_W-1:0];
      s2_rbit_s = 1'b0;
      if (!zero_s && (p_s >= MSB_MIN)) begin
         shift_s   = p_s - MSB_MIN;
         ext_s     = (MANT_W+1)'({s1_mag_r, 1'b0} >> shift_s);
         s2_exp_s  = EXP_W'(shift_s);
         s2_sig_s  = ext_s[MANT_W:1];
         s2_rbit_s = ext_s[0];
      end else begin
         s2_sig_s  = s1_mag_r[MANT_W-1:0];
      end
   end

   // S2 register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         s2_sign_r  <= 1'b0;
         s2_exp_r   <= {EXP_W{1'b0}};
         s2_sig_r   <= {MANT_W{1'b0}};
         s2_rbit_r  <= 1'b0;
         s2_sat_r   <= 1'b0;
         s2_rnd_r   <= 1'b0;
      end else if (ld2_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_sign_r <= s1_sign_r;
            s2_exp_r  <= s2_exp_s;
            s2_sig_r  <= s2_sig_s;
            s2_rbit_r <= s2_rbit_s;
            s2_sat_r  <= s1_sat_r;
            s2_rnd_r  <= s1_rnd_r;
         end
      end
   end

   // S3 combinational: round, carry into exponent, clamp at EMAX.
   always_comb begin
      inc_s    = (s2_rnd_r == RND_HALF_UP) && s2_rbit_r;
      s3_exp_s = s2_exp_r;
      s3_sig_s = s2_sig_r;
      rsat_s   = 1'b0;
      if (inc_s) begin
         if (s2_sig_r == SIG_ONES) begin
            if (s2_exp_r == EMAX_E) begin
               s3_sig_s = SIG_ONES;
               s3_exp_s = EMAX_E;
               rsat_s   = 1'b1;
            end else begin
               s3_sig_s = SIG_CARRY;
               s3_exp_s = s2_exp_r + EXP_W'(1);
            end
         end else begin
            s3_sig_s = s2_sig_r + MANT_W'(1);
         end
      end else begin
         s3_sig_s = s2_sig_r;
      end
   end

   // S3 register drives the outputs directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_valid_r <= 1'b0;
         s3_sign_r  <= 1'b0;
         s3_exp_r   <= {EXP_W{1'b0}};
         s3_sig_r   <= {MANT_W{1'b0}};
         s3_sat_r   <= 1'b0;
      end else if (ld3_s) begin
         s3_valid_r <= s2_valid_r;
         if (s2_valid_r) begin
            s3_sign_r <= s2_sign_r;
            s3_exp_r  <= s3_exp_s;
            s3_sig_r  <= s3_sig_s;
            s3_sat_r  <= s2_sat_r | rsat_s;
         end
      end
   end

   assign bus.out_valid = s3_valid_r;
   assign bus.out_sign  = s3_sign_r;
   assign bus.out_exp   = s3_exp_r;
   assign bus.out_sig   = s3_sig_r;
   assign bus.out_sat   = s3_sat_r;

endmodule
